facto_seq_ctrl: RTL and testbench

Parametrised factorial sequencer: next generation of the factorial controller, generalised to a `WIDTH`-bit datapath with a selectable step (n! or n!!), overflow tracking, busy/done status and a maskable completion interrupt. Sits between the bus-register block (start/clear/operand/control) and a multi-cycle `2*WIDTH`-product multiplier, driving the multiplier by start/done handshake and accumulating the running product.

---
 rtl/facto_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_facto_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/facto_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : facto_seq_ctrl
// Brief    : Factorial / double-factorial sequencer driving an external
//            multi-cycle multiplier through a start/done/clear handshake.
// Revision : 1.0 - initial release
// =============================================================================
module facto_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     operand,
    input  logic                 step_sel,
    input  logic                 intr_en,
    input  logic                 m_opdone,
    input  logic [2*WIDTH-1:0]   m_result,
    output logic                 m_start,
    output logic                 m_clear,
    output logic [WIDTH-1:0]     m_multiplicand,
    output logic [WIDTH-1:0]     m_multiplier,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic                 interrupt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_MUL_REQ  = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_MUL_CLR  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]         step_q, step_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               mclr_q, mclr_d;
    logic               irq_q, irq_d;

    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_cnt_next;
    logic               w_accept;

    assign w_step     = {{(WIDTH-2){1'b0}}, step_q};
    // Count saturates at zero so an even N!! cannot wrap around.
    assign w_cnt_next = (cnt_q > w_step) ? (cnt_q - w_step) : '0;
    assign w_accept   = op_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= 2'd1;
            result_q <= c_ONE;
            ovf_q    <= 1'b0;
            mclr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            mclr_q   <= mclr_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        mclr_d   = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                if (cnt_q <= c_ONE) begin
                    state_d = S_DONE;
                    mclr_d  = 1'b1;
                end else begin
                    state_d = S_MUL_REQ;
                end
            end
            S_MUL_REQ:  state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (m_opdone) begin
                    result_d = m_result[WIDTH-1:0];
                    ovf_d    = ovf_q | (|m_result[2*WIDTH-1:WIDTH]);
                    cnt_d    = w_cnt_next;
                    // Clear the multiplier on both exits: before the next
                    // request, or on entry to DONE.
                    mclr_d   = 1'b1;
                    state_d  = (w_cnt_next <= c_ONE) ? S_DONE : S_MUL_CLR;
                end
            end
            S_MUL_CLR:  state_d = S_MUL_REQ;
            S_DONE:     ;
            default:    state_d = S_IDLE;
        endcase

        if (w_accept) begin
            state_d  = S_LOAD;
            cnt_d    = operand;
            step_d   = step_sel ? 2'd2 : 2'd1;
            result_d = c_ONE;
            ovf_d    = 1'b0;
        end

        if (op_clear) begin
            state_d  = S_IDLE;
            result_d = c_ONE;
            ovf_d    = 1'b0;
            mclr_d   = 1'b1;
        end

        // Interrupt qualifies one cycle after DONE is entered.
        irq_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    assign m_start        = (state_q == S_MUL_REQ);
    assign m_clear        = mclr_q;
    assign m_multiplicand = result_q;
    assign m_multiplier   = cnt_q;
    assign result         = result_q;
    assign overflow       = ovf_q;
    assign busy           = (state_q == S_LOAD) || (state_q == S_MUL_REQ) ||
                            (state_q == S_MUL_WAIT) || (state_q == S_MUL_CLR);
    assign done           = (state_q == S_DONE);
    assign interrupt      = irq_q & intr_en;

endmodule
`default_nettype wire

// File: tb/tb_facto_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_facto_seq_ctrl
// Brief    : Bench running 8-bit and 64-bit sequencers in lockstep against a
//            behavioural multiplier and a factorial reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_facto_seq_ctrl;

    typedef struct {
        logic [63:0] r64;
        logic        ov64;
        logic [7:0]  r8;
        logic        ov8;
        int          edges;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n, op_start, op_clear, step_sel, intr_en;
    logic [63:0]  operand;

    logic         m8_opdone, m8_start, m8_clear, ov8, busy8, done8, irq8;
    logic [15:0]  m8_result, pend8;
    logic [7:0]   m8_mcand, m8_mplier, r8;
    logic         m64_opdone, m64_start, m64_clear, ov64, busy64, done64, irq64;
    logic [127:0] m64_result, pend64;
    logic [63:0]  m64_mcand, m64_mplier, r64;

    int           lat_cfg = 3;
    int           lat8, lat64, nstart8;
    logic         both_seen;
    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    facto_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .operand(operand[7:0]), .step_sel(step_sel), .intr_en(intr_en),
        .m_opdone(m8_opdone), .m_result(m8_result), .m_start(m8_start),
        .m_clear(m8_clear), .m_multiplicand(m8_mcand), .m_multiplier(m8_mplier),
        .result(r8), .overflow(ov8), .busy(busy8), .done(done8), .interrupt(irq8)
    );

    facto_seq_ctrl #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .operand(operand), .step_sel(step_sel), .intr_en(intr_en),
        .m_opdone(m64_opdone), .m_result(m64_result), .m_start(m64_start),
        .m_clear(m64_clear), .m_multiplicand(m64_mcand), .m_multiplier(m64_mplier),
        .result(r64), .overflow(ov64), .busy(busy64), .done(done64), .interrupt(irq64)
    );

    // Behavioural multipliers: done rises lat_cfg edges after m_start is sampled.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m8_opdone <= 1'b0; m8_result <= '0; pend8 <= '0; lat8 <= 0;
        end else if (m8_clear) begin
            m8_opdone <= 1'b0; lat8 <= 0;
        end else if (m8_start) begin
            if (lat_cfg == 1) begin
                m8_opdone <= 1'b1; m8_result <= 16'(m8_mcand) * 16'(m8_mplier);
            end else begin
                lat8 <= lat_cfg - 1; pend8 <= 16'(m8_mcand) * 16'(m8_mplier);
            end
        end else if (lat8 != 0) begin
            lat8 <= lat8 - 1;
            if (lat8 == 1) begin m8_opdone <= 1'b1; m8_result <= pend8; end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m64_opdone <= 1'b0; m64_result <= '0; pend64 <= '0; lat64 <= 0;
        end else if (m64_clear) begin
            m64_opdone <= 1'b0; lat64 <= 0;
        end else if (m64_start) begin
            if (lat_cfg == 1) begin
                m64_opdone <= 1'b1; m64_result <= 128'(m64_mcand) * 128'(m64_mplier);
            end else begin
                lat64 <= lat_cfg - 1; pend64 <= 128'(m64_mcand) * 128'(m64_mplier);
            end
        end else if (lat64 != 0) begin
            lat64 <= lat64 - 1;
            if (lat64 == 1) begin m64_opdone <= 1'b1; m64_result <= pend64; end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) nstart8 <= 0;
        else if (m8_start) nstart8 <= nstart8 + 1;
    end

    initial both_seen = 1'b0;
    always @(negedge clk)
        if ((m8_start && m8_clear) || (m64_start && m64_clear)) both_seen = 1'b1;

    function automatic exp_t model(input logic [63:0] n, input logic stp);
        exp_t         e;
        logic [127:0] p;
        logic [15:0]  p8;
        logic [63:0]  c, s;
        int           k;
        e.r64 = 64'd1; e.r8 = 8'd1; e.ov64 = 1'b0; e.ov8 = 1'b0;
        c = n; s = stp ? 64'd2 : 64'd1; k = 0;
        while (c > 64'd1) begin
            p      = 128'(e.r64) * 128'(c);
            e.ov64 = e.ov64 | (|p[127:64]);
            e.r64  = p[63:0];
            p8     = 16'(e.r8) * 16'(c[7:0]);
            e.ov8  = e.ov8 | (|p8[15:8]);
            e.r8   = p8[7:0];
            c      = (c > s) ? c - s : 64'd0;
            k++;
        end
        e.edges = (k == 0) ? 2 : 1 + k * (lat_cfg + 1) + (k - 1) + 1;
        return e;
    endfunction

    task automatic run_op(input logic [63:0] n, input logic stp, input bit busy_poke);
        exp_t e;
        int   edges, s0;
        sb.push_back(model(n, stp));
        s0 = nstart8;
        operand = n; step_sel = stp; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0; operand = 64'hFF; step_sel = ~stp;
        edges = 1;
        n_tests++;
        if (busy8 !== 1'b1 || busy64 !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start n=%0d got %b/%b exp 1", n, busy8, busy64);
        end
        while (!done8 && edges < 2000) begin
            op_start = busy_poke && (edges == 2);
            @(posedge clk); #1;
            edges++;
        end
        op_start = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (edges !== e.edges || done64 !== 1'b1) begin
            n_fail++; $display("FAIL done_timing n=%0d got %0d edges (done64=%b) exp %0d", n, edges, done64, e.edges);
        end
        n_tests++;
        if (r8 !== e.r8 || ov8 !== e.ov8) begin
            n_fail++; $display("FAIL result8 n=%0d got %0d ov %b exp %0d ov %b", n, r8, ov8, e.r8, e.ov8);
        end
        n_tests++;
        if (r64 !== e.r64 || ov64 !== e.ov64) begin
            n_fail++; $display("FAIL result64 n=%0d got %0d ov %b exp %0d ov %b", n, r64, ov64, e.r64, e.ov64);
        end
        n_tests++;
        if (busy8 !== 1'b0 || busy64 !== 1'b0) begin
            n_fail++; $display("FAIL busy_at_done n=%0d got %b/%b exp 0", n, busy8, busy64);
        end
        if (n <= 64'd1) begin
            n_tests++;
            if (nstart8 - s0 != 0) begin
                n_fail++; $display("FAIL no_mstart n=%0d got %0d pulses exp 0", n, nstart8 - s0);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0; step_sel = 1'b0;
        intr_en = 1'b0; operand = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (r8 !== 8'd1 || r64 !== 64'd1 || ov8 || ov64 || busy8 || done8 || irq8 || done64) begin
            n_fail++; $display("FAIL reset_status got r=%0d/%0d ov=%b bsy=%b dn=%b exp r=1 rest 0", r8, r64, ov8, busy8, done8);
        end
        n_tests++;
        if (m8_start || m8_clear || m8_mcand !== 8'd1 || m8_mplier !== 8'd0 || m64_mcand !== 64'd1) begin
            n_fail++; $display("FAIL reset_mult got st=%b cl=%b mc=%0d mp=%0d exp 0 0 1 0", m8_start, m8_clear, m8_mcand, m8_mplier);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fact5_irq();
        lat_cfg = 3; intr_en = 1'b1;
        run_op(64'd5, 1'b0, 1'b1);
        n_tests++;
        if (irq8 !== 1'b0) begin n_fail++; $display("FAIL irq_first_done got %b exp 0", irq8); end
        @(posedge clk); #1;
        n_tests++;
        if (irq8 !== 1'b1 || irq64 !== 1'b1) begin n_fail++; $display("FAIL irq_next got %b/%b exp 1", irq8, irq64); end
        intr_en = 1'b0; #1;
        n_tests++;
        if (irq8 !== 1'b0) begin n_fail++; $display("FAIL irq_mask got %b exp 0", irq8); end
    endtask

    task automatic test_small();
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < 2; n++)
                run_op(64'(n), s[0], 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(64'd7, 1'b1, 1'b0);
        run_op(64'd6, 1'b0, 1'b0);
        run_op(64'd3, 1'b0, 1'b0);
        lat_cfg = 1;
        run_op(64'd4, 1'b1, 1'b0);
        run_op(64'd8, 1'b1, 1'b0);
        lat_cfg = 3;
    endtask

    task automatic test_clear();
        operand = 64'd10; step_sel = 1'b0; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        for (int i = 0; i < 50 && !m8_start; i++) begin @(posedge clk); #1; end
        n_tests++;
        if (m8_start !== 1'b1) begin n_fail++; $display("FAIL clear_wait_mstart got %b exp 1", m8_start); end
        @(posedge clk); #1;
        op_clear = 1'b1; op_start = 1'b1; operand = 64'd3;
        @(posedge clk); #1;
        op_clear = 1'b0; op_start = 1'b0;
        n_tests++;
        if (busy8 || done8 || r8 !== 8'd1 || r64 !== 64'd1 || m8_clear !== 1'b1 || ov8) begin
            n_fail++; $display("FAIL clear_state got bsy=%b dn=%b r=%0d mclr=%b exp 0 0 1 1", busy8, done8, r8, m8_clear);
        end
        @(posedge clk); #1;
        n_tests++;
        if (m8_clear || busy8 || m64_clear) begin
            n_fail++; $display("FAIL clear_pulse got mclr=%b bsy=%b exp 0 0", m8_clear, busy8);
        end
        run_op(64'd4, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        operand = 64'd5; step_sel = 1'b0; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        for (int i = 0; i < 50 && !m8_start; i++) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (m8_start || m64_start || busy8 || r8 !== 8'd1 || m8_mplier !== 8'd0 || done8 || m8_clear) begin
            n_fail++; $display("FAIL async_reset got st=%b bsy=%b r=%0d mp=%0d exp 0 0 1 0", m8_start, busy8, r8, m8_mplier);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(64'd3, 1'b1, 1'b0);
    endtask

    task automatic test_protocol();
        n_tests++;
        if (both_seen !== 1'b0) begin n_fail++; $display("FAIL start_clear_overlap got %b exp 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_fact5_irq();
        test_small();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
